irq_controller: RTL and testbench
=================================

// Module: irq_controller
// PURPOSE
//   Interrupt source side of the CPU interrupt interface. Synchronises external
//   request lines, latches rising edges as pending, masks and priority-arbitrates
//   them, then presents one request (id + entry vector) to the CPU and holds it
//   until acknowledged. Tracks the in-service interrupt until the handler signals
//   completion. Replaces the ad-hoc posedge latches in front of the CPU's CP0 logic.
// PARAMETERS
//   NUM_SRC      3             number of request sources; highest index = highest priority
//   SYNC_STAGES  2             synchroniser depth per source (>=2)
//   VEC_BASE     32'h0000_0100 entry address of source 0
//   VEC_STRIDE   32'h0000_0020 address step between source entries
// PORTS
//   clk         in   1        clock, all state on rising edge
//   rst_n       in   1        asynchronous active-low reset
//   irq_src     in   NUM_SRC  asynchronous request lines, rising edge = request
//   mask_we     in   1        write enable for mask register
//   mask_wdata  in   NUM_SRC  new mask value (1 = source masked)
//   mask        out  NUM_SRC  current mask register
//   pending     out  NUM_SRC  latched, not yet acknowledged requests
//   in_service  out  NUM_SRC  acknowledged, not yet completed interrupts
//   irq_req     out  1        request to CPU
//   irq_id      out  clog2(NUM_SRC)  index of requested source, valid while irq_req
//   irq_vector  out  32       VEC_BASE + irq_id*VEC_STRIDE, valid while irq_req
//   irq_ack     in   1        CPU has taken the interrupt (one-cycle pulse)
//   irq_done    in   1        handler finished / eret (one-cycle pulse)
// BEHAVIOUR
//   - Reset: mask=0, pending=0, in_service=0, irq_req=0, irq_id=0,
//     irq_vector=VEC_BASE, sync/prev flops=0, FSM=IDLE. Reset mid-request drops
//     irq_req immediately (async) and discards all pending state.
//   - Edge detect: prev flop resets to 0, so a source already high at reset
//     release counts as one edge. Source rising before edge 1 -> pending set on
//     edge SYNC_STAGES+1, irq_req high after edge SYNC_STAGES+2.
//   - Repeated edges while pending already set merge into one request.
//   - Same-cycle ack-clear and new edge on the same source: set wins.
//   - mask_we: mask updated on the edge; used for arbitration from next cycle.
//     Masking never clears pending.
//   - Arbitration: highest index among pending & ~mask.
//   - FSM IDLE: any eligible source -> REQ; latch irq_id/irq_vector from winner.
//   - FSM REQ: irq_req=1; id/vector frozen (a higher source arriving does not
//     replace it). irq_ack -> clear pending[id], set in_service[id], irq_req=0,
//     -> SERVICE. If the latched source becomes masked before ack, irq_req=0,
//     -> IDLE, pending kept.
//   - FSM SERVICE: irq_req=0; irq_done -> clear in_service, -> IDLE. A new
//     request can rise at the earliest one cycle after irq_done.
//   - irq_ack outside REQ and irq_done outside SERVICE are ignored. Same-edge
//     irq_ack and irq_done in REQ: ack taken, done ignored.
// CONFIGURATION
//   IRQ_NEST_EN defined:
//     - In SERVICE, an eligible source of strictly higher priority than the
//       highest in_service bit moves FSM to REQ (nested request).
//     - Ack in REQ sets the additional in_service bit.
//     - irq_done clears only the highest set in_service bit; FSM -> IDLE only
//       when in_service becomes 0, else stays SERVICE.
//   IRQ_NEST_EN undefined:
//     - No request is raised while in SERVICE; in_service is one-hot or zero.
// TESTING
//   1 Reset release with irq_src=0, pulse irq_src[0] -> irq_req after
//     SYNC_STAGES+2 edges, irq_id=0, irq_vector=32'h100.
//   2 Rising edges on src[0] and src[2] in the same cycle -> irq_id=2,
//     vector=32'h140. After ack+done -> irq_id=0 request follows.
//   3 mask=3'b100, edge on src[2] -> pending=3'b100, no irq_req.
//     Write mask=0 -> irq_req one cycle later.
//   4 In REQ for id=1, set mask[1] -> irq_req drops, FSM IDLE, pending[1] stays 1.
//   5 Edge on src[1] on the same edge as irq_ack for id=1 -> pending[1]=1,
//     in_service=3'b010.
//   6 IRQ_NEST_EN: in SERVICE for id=0, edge on src[2] -> nested irq_req id=2;
//     ack -> in_service=3'b101; done -> 3'b001, FSM still SERVICE; done -> IDLE.
//     Without the macro: no irq_req until done.

Source files
------------

// File: rtl/irq_if.sv
// irq_if: interrupt controller bus; master = controller, slave = CPU/source side.
interface irq_if #(
  parameter int NUM_SRC = 3,
  parameter int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
);
  logic [NUM_SRC-1:0] irq_src;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_wdata;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] in_service;
  logic               irq_req;
  logic [ID_W-1:0]    irq_id;
  logic [31:0]        irq_vector;
  logic               irq_ack;
  logic               irq_done;
  modport master (
    input  irq_src, mask_we, mask_wdata, irq_ack, irq_done,
    output mask, pending, in_service, irq_req, irq_id, irq_vector
  );
  modport slave (
    output irq_src, mask_we, mask_wdata, irq_ack, irq_done,
    input  mask, pending, in_service, irq_req, irq_id, irq_vector
  );
endinterface

// File: rtl/irq_controller.sv
// irq_controller: sync, edge-latch, mask and priority-arbitrate interrupt sources for the CPU.
// Define IRQ_NEST_EN to allow strictly higher-priority requests to nest during service.
module irq_controller #(
  parameter int          NUM_SRC     = 3,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] VEC_BASE    = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE  = 32'h0000_0020
) (
  input logic  clk,
  input logic  rst_n,
  irq_if.master bus
);
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t                              state_q, state_d;
  logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q, sync_d;
  logic [NUM_SRC-1:0] prev_q, prev_d, pend_q, pend_d, mask_q, mask_d, isr_q, isr_d;
  logic [NUM_SRC-1:0] rise, elig, isr_top, id_hot;
  logic [ID_W-1:0]    id_q, id_d, win;
  logic [31:0]        vec_q, vec_d;
  logic               req, nest_ok;
`ifdef IRQ_NEST_EN
  logic [NUM_SRC-1:0] above;
`endif
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], bus.irq_src};
    prev_d  = sync_q[SYNC_STAGES-1];
    rise    = sync_q[SYNC_STAGES-1] & ~prev_q;
    mask_d  = bus.mask_we ? bus.mask_wdata : mask_q;
    elig    = pend_q & ~mask_q;
    win     = '0;
    isr_top = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (elig[i]) win = ID_W'(i);
      if (isr_q[i]) isr_top = NUM_SRC'(1) << i;
    end
`ifdef IRQ_NEST_EN
    above   = ~((isr_top << 1) - NUM_SRC'(1));
    nest_ok = |(elig & above);
`else
    nest_ok = 1'b0;
`endif
    id_hot  = NUM_SRC'(1) << id_q;
    // a latched source masked while waiting withdraws the request at once
    req     = (state_q == REQ) && !mask_q[id_q];
    state_d = state_q;
    id_d    = id_q;
    vec_d   = vec_q;
    pend_d  = pend_q | rise;
    isr_d   = isr_q;
    case (state_q)
      IDLE: if (|elig) begin
        state_d = REQ;
        id_d    = win;
        vec_d   = VEC_BASE + VEC_STRIDE * 32'(win);
      end
      REQ: if (!req) begin
        state_d = (|isr_q) ? SERVICE : IDLE;
      end else if (bus.irq_ack) begin
        pend_d  = (pend_q & ~id_hot) | rise;
        isr_d   = isr_q | id_hot;
        state_d = SERVICE;
      end
      SERVICE: if (bus.irq_done) begin
        isr_d   = isr_q & ~isr_top;
        state_d = (|isr_d) ? SERVICE : IDLE;
      end else if (nest_ok) begin
        state_d = REQ;
        id_d    = win;
        vec_d   = VEC_BASE + VEC_STRIDE * 32'(win);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sync_q  <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      isr_q   <= '0;
      id_q    <= '0;
      vec_q   <= VEC_BASE;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      isr_q   <= isr_d;
      id_q    <= id_d;
      vec_q   <= vec_d;
    end
  end
  assign bus.mask       = mask_q;
  assign bus.pending    = pend_q;
  assign bus.in_service = isr_q;
  assign bus.irq_req    = req;
  assign bus.irq_id     = id_q;
  assign bus.irq_vector = vec_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed stimulus with a stack-based behavioural model checked every cycle.
module tb_irq_controller;
  localparam int S = 2;
  localparam logic [31:0] BASE = 32'h100;
  localparam logic [31:0] STRIDE = 32'h20;
`ifdef IRQ_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  irq_if #(.NUM_SRC(3)) bus ();
  irq_controller #(.NUM_SRC(3), .SYNC_STAGES(S), .VEC_BASE(BASE), .VEC_STRIDE(STRIDE)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  logic [2:0] h [0:S+1];
  logic [2:0] m_mask, m_pend, m_rise, m_elig, m_np, exp_isr;
  int m_mode, m_id, m_best;
  int stk [$];
  logic exp_req;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k <= S + 1; k++) h[k] = '0;
    m_mask = '0;
    m_pend = '0;
    m_mode = 0;
    m_id = 0;
    stk.delete();
  endtask
  // mode: 0 idle, 1 requesting, 2 servicing; stk holds accepted ids, newest last
  task automatic model_step();
    m_rise = h[S] & ~h[S+1];
    for (int k = S + 1; k >= 2; k--) h[k] = h[k-1];
    h[1] = bus.irq_src;
    m_elig = m_pend & ~m_mask;
    m_best = -1;
    for (int i = 0; i < 3; i++) if (m_elig[i]) m_best = i;
    m_np = m_pend;
    if (m_mode == 0) begin
      if (m_best >= 0) begin m_mode = 1; m_id = m_best; end
    end else if (m_mode == 1) begin
      if (m_mask[m_id]) m_mode = (stk.size() > 0) ? 2 : 0;
      else if (bus.irq_ack) begin m_np[m_id] = 1'b0; stk.push_back(m_id); m_mode = 2; end
    end else begin
      if (bus.irq_done) begin
        void'(stk.pop_back());
        m_mode = (stk.size() > 0) ? 2 : 0;
      end else if (NEST && stk.size() > 0 && m_best > stk[$]) begin
        m_mode = 1; m_id = m_best;
      end
    end
    m_pend = m_np | m_rise;
    if (bus.mask_we) m_mask = bus.mask_wdata;
  endtask
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        exp_req = (m_mode == 1) && !m_mask[m_id];
        exp_isr = '0;
        foreach (stk[j]) exp_isr[stk[j]] = 1'b1;
        chk("m_req", 32'(bus.irq_req), 32'(exp_req));
        chk("m_pending", 32'(bus.pending), 32'(m_pend));
        chk("m_in_service", 32'(bus.in_service), 32'(exp_isr));
        chk("m_mask", 32'(bus.mask), 32'(m_mask));
        if (exp_req) begin
          chk("m_id", 32'(bus.irq_id), 32'(m_id));
          chk("m_vector", bus.irq_vector, BASE + STRIDE * 32'(m_id));
        end
      end
    end
  end
  task automatic step(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic pulse_src(input logic [2:0] v);
    bus.irq_src = v; step(); bus.irq_src = '0;
  endtask
  task automatic ack();
    bus.irq_ack = 1'b1; step(); bus.irq_ack = 1'b0;
  endtask
  task automatic done();
    bus.irq_done = 1'b1; step(); bus.irq_done = 1'b0;
  endtask
  task automatic wr_mask(input logic [2:0] v);
    bus.mask_we = 1'b1; bus.mask_wdata = v; step(); bus.mask_we = 1'b0;
  endtask
  initial begin
    bus.irq_src = '0; bus.mask_we = 1'b0; bus.mask_wdata = '0;
    bus.irq_ack = 1'b0; bus.irq_done = 1'b0;
    step(2);
    chk("rst_req", 32'(bus.irq_req), 32'd0);
    chk("rst_vector", bus.irq_vector, 32'h100);
    chk("rst_id", 32'(bus.irq_id), 32'd0);
    rst_n = 1'b1;
    step();
    // single source: pending on edge 3, request after edge 4
    pulse_src(3'b001); step();
    chk("t1_pend_e2", 32'(bus.pending), 32'd0);
    step();
    chk("t1_pend_e3", 32'(bus.pending), 32'b001);
    chk("t1_req_e3", 32'(bus.irq_req), 32'd0);
    step();
    chk("t1_req_e4", 32'(bus.irq_req), 32'd1);
    chk("t1_id", 32'(bus.irq_id), 32'd0);
    chk("t1_vec", bus.irq_vector, 32'h100);
    ack();
    chk("t1_isr", 32'(bus.in_service), 32'b001);
    chk("t1_pend_clr", 32'(bus.pending), 32'd0);
    done();
    chk("t1_isr_done", 32'(bus.in_service), 32'd0);
    // simultaneous sources: highest index first
    pulse_src(3'b101); step(3);
    chk("t2_id", 32'(bus.irq_id), 32'd2);
    chk("t2_vec", bus.irq_vector, 32'h140);
    ack();
    chk("t2_pend", 32'(bus.pending), 32'b001);
    done();
    chk("t2_req_idle", 32'(bus.irq_req), 32'd0);
    step();
    chk("t2_req2", 32'(bus.irq_req), 32'd1);
    chk("t2_id2", 32'(bus.irq_id), 32'd0);
    ack(); done();
    // masked source, two merged edges, then unmask
    wr_mask(3'b100);
    chk("t3_mask", 32'(bus.mask), 32'b100);
    pulse_src(3'b100); step(); pulse_src(3'b100); step(3);
    chk("t3_pend", 32'(bus.pending), 32'b100);
    chk("t3_noreq", 32'(bus.irq_req), 32'd0);
    wr_mask(3'b000);
    chk("t3_req_wait", 32'(bus.irq_req), 32'd0);
    step();
    chk("t3_req", 32'(bus.irq_req), 32'd1);
    chk("t3_id", 32'(bus.irq_id), 32'd2);
    ack();
    chk("t3_merged", 32'(bus.pending), 32'd0);
    done(); step();
    chk("t3_idle", 32'(bus.irq_req), 32'd0);
    // mask the latched source while requesting
    pulse_src(3'b010); step(3);
    chk("t4_req", 32'(bus.irq_req), 32'd1);
    wr_mask(3'b010);
    chk("t4_drop", 32'(bus.irq_req), 32'd0);
    chk("t4_pend", 32'(bus.pending), 32'b010);
    step();
    chk("t4_pend_kept", 32'(bus.pending), 32'b010);
    chk("t4_isr", 32'(bus.in_service), 32'd0);
    wr_mask(3'b000); step();
    chk("t4_rereq", 32'(bus.irq_req), 32'd1);
    chk("t4_id", 32'(bus.irq_id), 32'd1);
    // new edge on the acked source lands on the ack edge
    pulse_src(3'b010); step();
    ack();
    chk("t5_pend", 32'(bus.pending), 32'b010);
    chk("t5_isr", 32'(bus.in_service), 32'b010);
    done();
    chk("t5_isr_done", 32'(bus.in_service), 32'd0);
    step();
    chk("t5_req", 32'(bus.irq_req), 32'd1);
    chk("t5_id", 32'(bus.irq_id), 32'd1);
    ack(); done();
    chk("t5_clean", 32'(bus.pending), 32'd0);
    // higher source during service
    pulse_src(3'b001); step(3);
    chk("t6_req0", 32'(bus.irq_req), 32'd1);
    ack();
    chk("t6_isr0", 32'(bus.in_service), 32'b001);
    pulse_src(3'b100); step(3);
    if (NEST) begin
      chk("t6_nest_req", 32'(bus.irq_req), 32'd1);
      chk("t6_nest_id", 32'(bus.irq_id), 32'd2);
      chk("t6_nest_vec", bus.irq_vector, 32'h140);
      ack();
      chk("t6_isr101", 32'(bus.in_service), 32'b101);
      done();
      chk("t6_isr001", 32'(bus.in_service), 32'b001);
      step();
      chk("t6_still_svc", 32'(bus.irq_req), 32'd0);
      done();
      chk("t6_isr0", 32'(bus.in_service), 32'd0);
    end else begin
      chk("t6_noreq", 32'(bus.irq_req), 32'd0);
      chk("t6_pend", 32'(bus.pending), 32'b100);
      step(2);
      chk("t6_noreq2", 32'(bus.irq_req), 32'd0);
      done();
      chk("t6_isr0", 32'(bus.in_service), 32'd0);
      step();
      chk("t6_req2", 32'(bus.irq_req), 32'd1);
      chk("t6_id2", 32'(bus.irq_id), 32'd2);
      ack(); done();
    end
    // async reset mid-request, source held high across release
    pulse_src(3'b010); step(3);
    chk("t7_req", 32'(bus.irq_req), 32'd1);
    #2 rst_n = 1'b0; bus.irq_src = 3'b001;
    #1;
    chk("t7_async_req", 32'(bus.irq_req), 32'd0);
    chk("t7_async_pend", 32'(bus.pending), 32'd0);
    chk("t7_async_vec", bus.irq_vector, 32'h100);
    step();
    rst_n = 1'b1;
    step(3);
    chk("t7_held_pend", 32'(bus.pending), 32'b001);
    step();
    chk("t7_held_req", 32'(bus.irq_req), 32'd1);
    chk("t7_held_id", 32'(bus.irq_id), 32'd0);
    bus.irq_src = '0;
    ack(); done(); step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
